// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcodes and helpers for the execute stage.
package exe_stage_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 12;
    localparam int REG_W  = 3;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADDC = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_SUBC = 4'h3;
    localparam logic [OP_W-1:0] OP_AND  = 4'h4;
    localparam logic [OP_W-1:0] OP_OR   = 4'h5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
    localparam logic [OP_W-1:0] OP_PASS = 4'h7;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h8;
    localparam logic [OP_W-1:0] OP_SUBI = 4'h9;
    localparam logic [OP_W-1:0] OP_ANDI = 4'hA;
    localparam logic [OP_W-1:0] OP_ORI  = 4'hB;
    localparam logic [OP_W-1:0] OP_SHL  = 4'hC;
    localparam logic [OP_W-1:0] OP_SHR  = 4'hD;
    localparam logic [OP_W-1:0] OP_BZ   = 4'hE;
    localparam logic [OP_W-1:0] OP_BC   = 4'hF;

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_BZ) || (op == OP_BC);
    endfunction

    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // MEM-stage result is younger than WB, so it wins when both match.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_W-1:0]  addr,
        input logic [DATA_W-1:0] reg_data,
        input logic              mem_wr,
        input logic [REG_W-1:0]  mem_rd,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_wr,
        input logic [REG_W-1:0]  wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        if (mem_wr && (mem_rd == addr)) return mem_data;
        if (wb_wr && (wb_rd == addr))   return wb_data;
        return reg_data;
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU with 9-bit internal arithmetic; bit 8 is carry/borrow.
module alu8
    import exe_stage_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    logic [DATA_W:0] wide;
    logic [DATA_W:0] a_ext;
    logic [DATA_W:0] b_ext;
    logic [DATA_W:0] c_ext;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};
    assign c_ext = {{DATA_W{1'b0}}, cin};

    always_comb begin
        wide = '0;
        case (op)
            OP_ADD, OP_ADDI: wide = a_ext + b_ext;
            OP_ADDC:         wide = a_ext + b_ext + c_ext;
            // Wrapped 9-bit difference: bit 8 set exactly when A < B + Cin.
            OP_SUB, OP_SUBI: wide = a_ext - b_ext;
            OP_SUBC:         wide = a_ext - b_ext - c_ext;
            OP_AND, OP_ANDI: wide = {1'b0, a & b};
            OP_OR,  OP_ORI:  wide = {1'b0, a | b};
            OP_XOR:          wide = {1'b0, a ^ b};
            OP_PASS:         wide = b_ext;
            OP_SHL:          wide = {a, 1'b0};
            OP_SHR:          wide = {a[0], 1'b0, a[DATA_W-1:1]};
            default:         wide = '0;
        endcase
        result = wide[DATA_W-1:0];
        cout   = wide[DATA_W];
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, C/Z flag registers, branch resolve
// and the EXE/MEM pipeline register.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              regWr_IN,
    input  logic              memRd_IN,
    input  logic              memWr_IN,
    input  logic              cWr_IN,
    input  logic              zWr_IN,
    input  logic [OP_W-1:0]   aluOp_IN,
    input  logic [REG_W-1:0]  rd_IN,
    input  logic [REG_W-1:0]  rs_IN,
    input  logic [REG_W-1:0]  rt_IN,
    input  logic [DATA_W-1:0] regData1_IN,
    input  logic [DATA_W-1:0] regData2_IN,
    input  logic [DATA_W-1:0] immConst_IN,
    input  logic [DATA_W-1:0] brDisp_IN,
    input  logic [PC_W-1:0]   pcPlus1_IN,
    input  logic              memRegWr,
    input  logic [REG_W-1:0]  memRd,
    input  logic [DATA_W-1:0] memData,
    input  logic              wbRegWr,
    input  logic [REG_W-1:0]  wbRd,
    input  logic [DATA_W-1:0] wbData,
    input  logic              flush,
    output logic              regWr_OUT,
    output logic              memRd_OUT,
    output logic              memWr_OUT,
    output logic [REG_W-1:0]  rd_OUT,
    output logic [DATA_W-1:0] aluResult_OUT,
    output logic [DATA_W-1:0] storeData_OUT,
    output logic              brTaken_OUT,
    output logic [PC_W-1:0]   brTarget_OUT,
    output logic              carry_OUT,
    output logic              zero_OUT
);

    logic [REG_W-1:0]  src_addr [2];
    logic [DATA_W-1:0] src_data [2];
    logic [DATA_W-1:0] fwd_data [2];

    assign src_addr[0] = rs_IN;
    assign src_addr[1] = rt_IN;
    assign src_data[0] = regData1_IN;
    assign src_data[1] = regData2_IN;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_data[gi] = fwd_sel(src_addr[gi], src_data[gi],
                                          memRegWr, memRd, memData,
                                          wbRegWr, wbRd, wbData);
        end
    endgenerate

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              branch;
    logic              br_cond;
    logic [PC_W-1:0]   br_target;

    assign op_a = fwd_data[0];
    assign op_b = uses_imm(aluOp_IN) ? immConst_IN : fwd_data[1];

    alu8 u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (aluOp_IN),
        .cin    (carry_OUT),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // Branches read the flag registers as left by the previous instruction.
    assign branch    = is_branch(aluOp_IN);
    assign br_cond   = (aluOp_IN == OP_BZ) ? zero_OUT : carry_OUT;
    assign br_target = pcPlus1_IN + {{(PC_W-DATA_W){brDisp_IN[DATA_W-1]}}, brDisp_IN};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWr_OUT     <= 1'b0;
            memRd_OUT     <= 1'b0;
            memWr_OUT     <= 1'b0;
            rd_OUT        <= '0;
            aluResult_OUT <= '0;
            storeData_OUT <= '0;
            brTaken_OUT   <= 1'b0;
            brTarget_OUT  <= '0;
            carry_OUT     <= 1'b0;
            zero_OUT      <= 1'b0;
        end else if (flush) begin
            regWr_OUT     <= 1'b0;
            memRd_OUT     <= 1'b0;
            memWr_OUT     <= 1'b0;
            rd_OUT        <= '0;
            aluResult_OUT <= '0;
            storeData_OUT <= '0;
            brTaken_OUT   <= 1'b0;
            brTarget_OUT  <= '0;
        end else begin
            regWr_OUT     <= regWr_IN & ~branch;
            memRd_OUT     <= memRd_IN & ~branch;
            memWr_OUT     <= memWr_IN & ~branch;
            rd_OUT        <= rd_IN;
            aluResult_OUT <= alu_result;
            storeData_OUT <= fwd_data[1];
            brTaken_OUT   <= branch & br_cond;
            brTarget_OUT  <= br_target;
            if (cWr_IN && !branch) carry_OUT <= alu_cout;
            if (zWr_IN && !branch) zero_OUT  <= (alu_result == '0);
        end
    end

endmodule
